// File: rtl/rv_div_pkg.sv
// Shared definitions for the RV32M multi-cycle divider: widths, op and state
// encodings, special-case constants and the two's-complement helper.
package rv_div_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic [XLEN-1:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

  function automatic logic [XLEN-1:0] neg2(input logic [XLEN-1:0] x);
    return ~x + XLEN'(1);
  endfunction

endpackage

// File: rtl/rv_div_unit_adder.sv
// Shared 32-bit add/sub adder: s = x + y (sub=0) or x - y (sub=1);
// cout is the carry out, i.e. 1 means no borrow on a subtraction.
module rv_div_unit_adder
  import rv_div_pkg::*;
(
  input  logic            sub,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  output logic            cout,
  output logic [XLEN-1:0] s
);

  logic [XLEN:0] sum;

  always_comb begin
    sum = {1'b0, x} + {1'b0, (sub ? ~y : y)} + {{XLEN{1'b0}}, sub};
    cout = sum[XLEN];
    s    = sum[XLEN-1:0];
  end

endmodule

// File: rtl/rv_div_unit.sv
// RV32M divider (DIV/DIVU/REM/REMU): restoring division, one trial subtraction
// per cycle through the shared adder; result returned with a one-cycle valid pulse.
module rv_div_unit
  import rv_div_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  state_e          state;
  op_e             op_q;
  logic [XLEN-1:0] a_q, b_q, babs, rem, quo, result_q;
  logic [4:0]      cnt;
  logic            neg_q, neg_r, valid_q;

  logic            sgn, is_rem, sa, sb, msb, cout, ok;
  logic [XLEN-1:0] aabs, babs_n, rs, diff;

  always_comb begin
    sgn    = (op_q == OP_DIV) || (op_q == OP_REM);
    is_rem = (op_q == OP_REM) || (op_q == OP_REMU);
    sa     = sgn & a_q[XLEN-1];
    sb     = sgn & b_q[XLEN-1];
    aabs   = sa ? neg2(a_q) : a_q;
    babs_n = sb ? neg2(b_q) : b_q;
    // R's msb shifted out means the partial remainder is >= 2^32 > |b|
    msb    = rem[XLEN-1];
    rs     = {rem[XLEN-2:0], quo[XLEN-1]};
    ok     = msb | cout;
  end

  rv_div_unit_adder u_adder (
    .sub  (1'b1),
    .x    (rs),
    .y    (babs),
    .cout (cout),
    .s    (diff)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= OP_DIV;
      a_q      <= '0;
      b_q      <= '0;
      babs     <= '0;
      rem      <= '0;
      quo      <= '0;
      result_q <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (flush_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              op_q  <= op_e'(op_i);
              a_q   <= dividend_i;
              b_q   <= divisor_i;
              state <= PREP;
            end
          end
          PREP: begin
            if (b_q == '0) begin
              result_q <= is_rem ? a_q : DIV0_Q;
              valid_q  <= 1'b1;
              state    <= DONE;
            end else if (sgn && (a_q == INT_MIN) && (b_q == '1)) begin
              result_q <= is_rem ? '0 : INT_MIN;
              valid_q  <= 1'b1;
              state    <= DONE;
            end else begin
              rem   <= '0;
              quo   <= aabs;
              babs  <= babs_n;
              cnt   <= '0;
              neg_q <= sa ^ sb;
              neg_r <= sa;
              state <= CALC;
            end
          end
          CALC: begin
            rem <= ok ? diff : rs;
            quo <= {quo[XLEN-2:0], ok};
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) state <= FIX;
          end
          FIX: begin
            // Sign fix-up is registered here so result and valid appear together in DONE
            result_q <= is_rem ? (neg_r ? neg2(rem) : rem)
                               : (neg_q ? neg2(quo) : quo);
            valid_q  <= 1'b1;
            state    <= DONE;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    ready_o  = (state == IDLE);
    busy_o   = ~ready_o;
    valid_o  = valid_q;
    result_o = result_q;
  end

endmodule

// File: tb/tb_rv_div_unit.sv
// Self-checking bench for rv_div_unit: directed vector table, control corner
// sequences and back-to-back random ops, all checked through a result scoreboard.
module tb_rv_div_unit;

  logic        clk = 1'b0;
  logic        rst, start_i, flush_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i, divisor_i;
  logic        ready_o, busy_o, valid_o;
  logic [31:0] result_o;

  rv_div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .flush_i    (flush_i),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .result_o   (result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    int          lat;
    int          issued;
  } sb_t;

  vec_t tv[16];
  sb_t  sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   nvalid   = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b, output int lat);
    logic [31:0] q, r;
    lat = 35;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; lat = 2;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; lat = 2;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  // Waits (bounded) for ready_o, drives a one-cycle start, optionally tracks the result.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit track);
    int w = 0;
    while (!ready_o && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("issue_ready", {31'd0, ready_o}, 32'd1);
    if (track) sbq.push_back('{exp: exp, lat: lat, issued: cyc});
    start_i    = 1'b1;
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sbq.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("drain_queue_empty", sbq.size(), 32'd0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin : mon
    sb_t e;
    if (!rst) begin
      if (valid_o) begin
        nvalid++;
        check("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_valid: valid_o=1 result=%08h, expected no valid", result_o);
        end else begin
          e = sbq.pop_front();
          check("result", result_o, e.exp);
          check("latency", cyc - e.issued, e.lat);
        end
      end
      prev_valid = valid_o;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, nv0, lat, sel;
    logic [1:0]  rop;
    logic [31:0] ra, rb, rexp;

    tv[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         35};
    tv[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          35};
    tv[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  35};
    tv[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  35};
    tv[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          35};
    tv[5]  = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          35};
    tv[6]  = '{2'b11, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          35};
    tv[7]  = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  35};
    tv[8]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  2};
    tv[9]  = '{2'b11, 32'd5,          32'd0,          32'd5,          2};
    tv[10] = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2};
    tv[11] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          2};
    tv[12] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          35};
    tv[13] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  35};
    tv[14] = '{2'b00, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          35};
    tv[15] = '{2'b10, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  2};

    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
    op_i = 2'b00; dividend_i = '0; divisor_i = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", {31'd0, ready_o}, 32'd1);
    check("reset_busy",  {31'd0, busy_o},  32'd0);
    check("reset_valid", {31'd0, valid_o}, 32'd0);
    check("reset_result", result_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Busy window: ready_o low in cycles 1..35, high again in cycle 36
    issue(2'b01, 32'd100, 32'd7, 32'd14, 35, 1'b1);
    bad = 0;
    for (int k = 1; k <= 35; k++) begin
      if (ready_o !== 1'b0 || busy_o !== 1'b1) bad++;
      @(negedge clk);
    end
    check("busy_window_errors", bad, 32'd0);
    check("ready_back_cycle36", {31'd0, ready_o}, 32'd1);
    check("busy_back_cycle36",  {31'd0, busy_o},  32'd0);

    for (int i = 0; i < 16; i++)
      issue(tv[i].op, tv[i].a, tv[i].b, tv[i].exp, tv[i].lat, 1'b1);
    drain();

    // Flush in CALC (cnt=10, cycle 12): no valid, result held
    issue(2'b01, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
    nv0 = nvalid;
    repeat (11) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_ready_next", {31'd0, ready_o}, 32'd1);

    // Flush in IDLE blocks a simultaneous start
    flush_i = 1'b1; start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd9; divisor_i = 32'd3;
    @(negedge clk);
    flush_i = 1'b0; start_i = 1'b0;
    check("idle_flush_blocks_start", {31'd0, ready_o}, 32'd1);
    repeat (40) @(negedge clk);
    check("flush_no_valid", nvalid - nv0, 32'd0);
    check("flush_result_held", result_o, tv[15].exp);

    // Start while busy is ignored
    issue(2'b11, 32'd100, 32'd7, 32'd2, 35, 1'b1);
    repeat (4) @(negedge clk);
    start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd55; divisor_i = 32'd5;
    @(negedge clk);
    start_i = 1'b0;
    check("start_while_busy_still_busy", {31'd0, busy_o}, 32'd1);
    drain();
    repeat (40) @(negedge clk);
    check("start_while_busy_result", result_o, 32'd2);

    // Reset mid-CALC (cnt=20, cycle 22)
    issue(2'b01, 32'h1234_5678, 32'd3, 32'd0, 0, 1'b0);
    nv0 = nvalid;
    repeat (21) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready",  {31'd0, ready_o}, 32'd1);
    check("midrst_busy",   {31'd0, busy_o},  32'd0);
    check("midrst_valid",  {31'd0, valid_o}, 32'd0);
    check("midrst_result", result_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_no_valid", nvalid - nv0, 32'd0);

    // Random back-to-back traffic
    for (int n = 0; n < 1000; n++) begin
      rop = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      ra  = (sel == 3) ? 32'h8000_0000 : $urandom;
      case (sel)
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2, 3:    rb = 32'hFFFF_FFFF;
        4:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      rexp = model(rop, ra, rb, lat);
      issue(rop, ra, rb, rexp, lat, 1'b1);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
